track_sensor_conditioner: RTL
=============================

Name: track_sensor_conditioner

Overview:
- Upstream conditioning stage for the track-control FSM.
- Takes the five raw reed/optical track sensors (s1..s5) as s_raw[4:0], synchronises and debounces each channel, and delivers clean levels (s_lvl) that drive the FSM sensor inputs directly.
- Also emits per-channel rise/fall pulses, a last-hit sensor code, a rise event counter and stuck-sensor fault flags for display and diagnostics.

Parameters:
- N_SENS, 5: number of sensor channels. Fixed at 5 because the last_hit encoding depends on it.
- DEBOUNCE_CYCLES, 1000: consecutive synced samples required to accept a level change (1 ms at 1 MHz). Legal range is 1..65535.
- STUCK_CYCLES, 50000: cycles a channel may stay high before it is flagged stuck. Legal range is 1..65535 and must be greater than DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, 1 MHz nominal.
- reset  input  1  asynchronous, active-high reset.
- s_raw  input  5  raw sensor inputs, asynchronous to clk. Bit 0 = s1 … bit 4 = s5.
- s_lvl  output  5  debounced sensor levels, registered.
- s_rise  output  5  one-cycle pulse when s_lvl rises, per channel.
- s_fall  output  5  one-cycle pulse when s_lvl falls, per channel.
- last_hit  output  3  number (1..5) of the sensor that rose most recently; 0 = none since reset.
- event_cnt  output  8  total accepted rising events, modulo 256.
- stuck  output  5  per-channel stuck-high fault flag.
- any_stuck  output  1  OR of stuck[4:0].

Behaviour:
- Reset: while reset=1, every register clears immediately (asynchronously) to 0. This covers the synchronisers, channel FSMs, counters, s_lvl, s_rise, s_fall, last_hit, event_cnt, stuck and any_stuck.
- Synchroniser: 2-flop chain per channel, giving sync1 and then sync2. All logic below uses sync2 only.
- Channel FSM, four states, each with a 16-bit debounce counter dcnt:
  - LOW: if sync2=1, go to CONF_H with dcnt=1. If DEBOUNCE_CYCLES=1, go straight to HIGH instead.
  - CONF_H: while sync2=1, dcnt increments. When sync2=1 and dcnt=DEBOUNCE_CYCLES-1, go to HIGH. If sync2=0, return to LOW and clear dcnt.
  - HIGH: mirror of LOW. If sync2=0, go to CONF_L with dcnt=1 (or straight to LOW when DEBOUNCE_CYCLES=1).
  - CONF_L: mirror of CONF_H. It resolves to LOW after DEBOUNCE_CYCLES consecutive 0 samples; any sync2=1 returns it to HIGH.
- s_lvl is 1 in HIGH and CONF_L, and 0 in LOW and CONF_H.
- Latency: let E0 be the first clk edge at which the new raw value is sampled into sync1. s_lvl changes at edge E0+DEBOUNCE_CYCLES+1, provided the raw value stays stable throughout.
- Glitch rejection: a pulse shorter than DEBOUNCE_CYCLES synced samples produces no s_lvl change, no pulse and no counter update.
- s_rise[i] / s_fall[i]: registered, high for exactly the one cycle in which s_lvl[i] takes its new value. They are never asserted together on the same channel.
- last_hit: updated in the same cycle that s_rise is asserted.
  - If several channels rise in the same cycle, the lowest index wins (s1 before s5).
  - With no rise, last_hit holds its value.
- event_cnt: incremented by the popcount of s_rise in that cycle, wrapping 255 to 0.
- Stuck detection: each channel has a 16-bit counter scnt.
  - scnt increments every cycle s_lvl=1 and saturates at STUCK_CYCLES.
  - stuck[i] sets when scnt reaches STUCK_CYCLES.
  - scnt and stuck[i] clear in the cycle s_lvl[i] falls.
  - Stuck does not alter s_lvl, so the FSM downstream still sees the level.
- any_stuck: registered OR of the next-state stuck bits, so it updates in the same cycle as stuck.
- Reset mid-operation:
  - All outputs return to 0 immediately, even if a sensor is high.
  - After reset is released, a still-high raw input is re-qualified through the full debounce path. It then produces s_rise, a last_hit update and an event_cnt increment exactly as for a new event.
- Independence: channels do not interact, except through the lowest-index priority on last_hit.

Test Plan (DEBOUNCE_CYCLES=4, STUCK_CYCLES=20):
- Reset then clean rise: reset held 3 cycles, then s_raw=5'b00100 stable.
  - s_lvl[2] must rise at E0+5, with s_rise=5'b00100 for that one cycle only.
  - last_hit must be 3 and event_cnt must be 1.
- Glitch rejection: s_raw[0] high for 3 cycles, then low.
  - s_lvl, s_rise, last_hit and event_cnt must stay 0 throughout.
- Bounce on fall: channel 1 stable high, then pattern 0,1,0,0,0,0 on s_raw[1].
  - s_lvl[1] must stay 1 through the bounce, then fall 5 edges after the final 0 run begins.
  - s_fall[1] must pulse once.
- Simultaneous rise: s_raw=5'b10010 applied in the same cycle.
  - s_rise=5'b10010, last_hit=2, and event_cnt must increase by 2.
- Stuck and counter wrap:
  - Hold s_raw[4] high: stuck[4] and any_stuck must assert once scnt reaches 20. Releasing the input must clear both on the s_fall cycle.
  - Drive 256 rise events on channel 0: event_cnt must wrap to 0.
- Reset mid-operation: assert reset while s_raw[3]=1 and s_lvl[3]=1.
  - All outputs must go to 0 immediately.
  - After release, s_lvl[3] and s_rise[3] must reassert after the full debounce, with last_hit=4.

Source files
------------

// File: rtl/track_sensor_conditioner.sv
// Track sensor conditioner: per-channel sync + debounce + stuck detection,
// plus shared last-hit encoder and rising-event counter.

module tsc_channel #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int STUCK_CYCLES    = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic lvl,
    output logic rise,
    output logic fall,
    output logic stuck,
    output logic rise_n,
    output logic stuck_n
);
    typedef enum logic [1:0] {LOW, CONF_H, HIGH, CONF_L} ch_state_t;

    localparam logic [15:0] D_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] S_MAX  = 16'(STUCK_CYCLES);
    localparam bit          D_ONE  = (DEBOUNCE_CYCLES == 1);

    ch_state_t   state, state_n;
    logic [15:0] dcnt, dcnt_n;
    logic [15:0] scnt, scnt_n;
    logic        sync1, sync2;
    logic        lvl_n, fall_n;

    // Two-flop synchroniser for the asynchronous raw input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce FSM and output state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOW;
            dcnt  <= '0;
            scnt  <= '0;
            lvl   <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            stuck <= 1'b0;
        end else begin
            state <= state_n;
            dcnt  <= dcnt_n;
            scnt  <= scnt_n;
            lvl   <= lvl_n;
            rise  <= rise_n;
            fall  <= fall_n;
            stuck <= stuck_n;
        end
    end

    // Next-state: a level change is accepted only after DEBOUNCE_CYCLES
    // consecutive agreeing samples; any disagreement snaps back
    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        unique case (state)
            LOW: if (sync2) begin
                if (D_ONE) begin state_n = HIGH;   dcnt_n = '0;    end
                else       begin state_n = CONF_H; dcnt_n = 16'd1; end
            end
            CONF_H: begin
                if (!sync2)              begin state_n = LOW;  dcnt_n = '0; end
                else if (dcnt == D_LAST) begin state_n = HIGH; dcnt_n = '0; end
                else                     dcnt_n = dcnt + 16'd1;
            end
            HIGH: if (!sync2) begin
                if (D_ONE) begin state_n = LOW;    dcnt_n = '0;    end
                else       begin state_n = CONF_L; dcnt_n = 16'd1; end
            end
            CONF_L: begin
                if (sync2)               begin state_n = HIGH; dcnt_n = '0; end
                else if (dcnt == D_LAST) begin state_n = LOW;  dcnt_n = '0; end
                else                     dcnt_n = dcnt + 16'd1;
            end
            default: begin state_n = LOW; dcnt_n = '0; end
        endcase
    end

    // Level/edge outputs and stuck-high timer; the timer counts cycles
    // already spent with lvl=1 and saturates so stuck stays set
    always_comb begin
        lvl_n  = (state_n == HIGH) || (state_n == CONF_L);
        rise_n = lvl_n & ~lvl;
        fall_n = ~lvl_n & lvl;
        scnt_n = scnt;
        if (fall_n)
            scnt_n = '0;
        else if (lvl && scnt != S_MAX)
            scnt_n = scnt + 16'd1;
        stuck_n = ~fall_n & (scnt_n == S_MAX);
    end
endmodule

module track_sensor_conditioner #(
    parameter int N_SENS          = 5,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int STUCK_CYCLES    = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SENS-1:0] s_raw,
    output logic [N_SENS-1:0] s_lvl,
    output logic [N_SENS-1:0] s_rise,
    output logic [N_SENS-1:0] s_fall,
    output logic [2:0]        last_hit,
    output logic [7:0]        event_cnt,
    output logic [N_SENS-1:0] stuck,
    output logic              any_stuck
);
    logic [N_SENS-1:0] rise_n, stuck_n;
    logic [2:0]        hit_n;
    logic [7:0]        cnt_n;

    for (genvar g = 0; g < N_SENS; g++) begin : g_ch
        tsc_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .STUCK_CYCLES   (STUCK_CYCLES)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .raw    (s_raw[g]),
            .lvl    (s_lvl[g]),
            .rise   (s_rise[g]),
            .fall   (s_fall[g]),
            .stuck  (stuck[g]),
            .rise_n (rise_n[g]),
            .stuck_n(stuck_n[g])
        );
    end

    // Lowest-index rising channel wins; popcount feeds the event counter
    always_comb begin
        hit_n = last_hit;
        cnt_n = event_cnt;
        for (int i = N_SENS - 1; i >= 0; i--)
            if (rise_n[i]) hit_n = 3'(i + 1);
        for (int i = 0; i < N_SENS; i++)
            cnt_n = cnt_n + 8'(rise_n[i]);
    end

    // Shared registers update on the same edge as the per-channel pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_hit  <= '0;
            event_cnt <= '0;
            any_stuck <= 1'b0;
        end else begin
            last_hit  <= hit_n;
            event_cnt <= cnt_n;
            any_stuck <= |stuck_n;
        end
    end
endmodule
